// File: rtl/stim_pkg.sv
// Shared constants, state encoding and step helpers for the stimulus sequencer.
// Lane feedback taps bits 7,5,4,3; MISR taps bits 31,21,1,0 (x^32+x^22+x^2+x+1).
package stim_pkg;

  localparam logic [7:0]  LANE0_SEED = 8'h55;
  localparam logic [7:0]  LANE1_SEED = 8'h5A;
  localparam logic [7:0]  LANE2_SEED = 8'h6A;
  localparam logic [7:0]  LANE3_SEED = 8'hAB;
  localparam logic [7:0]  LANE_TAPS  = 8'hB8;

  localparam logic [31:0] MISR_INIT  = 32'hFFFF_FFFF;
  localparam logic [31:0] MISR_TAPS  = 32'h8020_0003;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [7:0] lane_step(input logic [7:0] r);
    return {r[6:0], ^(r & LANE_TAPS)};
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], ^(s & MISR_TAPS)} ^ d;
  endfunction

endpackage

// File: rtl/stim_sequencer_lane.sv
// One 8-bit LFSR lane: reloads SEED on load (priority), else advances STEPS shifts on adv.
// Single-cycle update; no handshake of its own, the owner decides when to advance.
module lfsr8_lane
  import stim_pkg::*;
#(
  parameter logic [7:0] SEED  = 8'h01,
  parameter int         STEPS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       adv,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;
  logic [7:0] stepped;

  always_comb begin
    stepped = q_q;
    for (int i = 0; i < STEPS; i++) begin
      stepped = lane_step(stepped);
    end
    q_d = q_q;
    if (load) begin
      q_d = SEED;
    end else if (adv) begin
      q_d = stepped;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= SEED;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/stim_sequencer.sv
// Bounded LFSR stimulus campaign over valid/ready, counting DUT results; optional MISR (STIM_SEQ_SIGNATURE_EN).
// Vector visible the cycle after start; a/b held while in_ready is low; results counted in RUN/DRAIN only.
module stim_sequencer
  import stim_pkg::*;
#(
  parameter int STEPS = 3,
  parameter int CNT_W = 16,
  parameter int RES_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  output logic             in_valid,
  input  logic             in_ready,
  output logic [15:0]      a,
  output logic [15:0]      b,
  input  logic             res_valid,
  input  logic [RES_W-1:0] res_data,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [31:0]      sig
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;
  logic [CNT_W-1:0] num_vec_q, num_vec_d;
  logic             err_q, err_d;
  logic             start_acc;
  logic             xfer;
  logic             res_ok;
  logic [7:0]       lane0, lane1, lane2, lane3;

  assign start_acc = start && ((state_q == IDLE) || (state_q == DONE));
  assign xfer      = (state_q == RUN) && in_ready;
  assign res_ok    = res_valid && ((state_q == RUN) || (state_q == DRAIN))
                     && (res_cnt_q != num_vec_q);

  always_comb begin
    state_d   = state_q;
    vec_cnt_d = vec_cnt_q;
    res_cnt_d = res_cnt_q;
    num_vec_d = num_vec_q;
    err_d     = err_q;

    if (start_acc) begin
      vec_cnt_d = '0;
      res_cnt_d = '0;
      err_d     = 1'b0;
      num_vec_d = num_vec;
      state_d   = (num_vec == '0) ? DONE : RUN;
    end

    if (xfer) begin
      vec_cnt_d = vec_cnt_q + 1'b1;
      if (vec_cnt_d == num_vec_q) begin
        state_d = DRAIN;
      end
    end

    if (res_ok) begin
      res_cnt_d = res_cnt_q + 1'b1;
    end else if (res_valid) begin
      err_d = 1'b1;
    end

    // Final result may land in the same cycle the state is evaluated.
    if ((state_q == DRAIN) && (res_cnt_d == num_vec_q)) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      vec_cnt_q <= '0;
      res_cnt_q <= '0;
      num_vec_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      vec_cnt_q <= vec_cnt_d;
      res_cnt_q <= res_cnt_d;
      num_vec_q <= num_vec_d;
      err_q     <= err_d;
    end
  end

  lfsr8_lane #(.SEED(LANE0_SEED), .STEPS(STEPS)) u_lane0 (
    .clk(clk), .rst(rst), .load(start_acc), .adv(xfer), .q(lane0));
  lfsr8_lane #(.SEED(LANE1_SEED), .STEPS(STEPS)) u_lane1 (
    .clk(clk), .rst(rst), .load(start_acc), .adv(xfer), .q(lane1));
  lfsr8_lane #(.SEED(LANE2_SEED), .STEPS(STEPS)) u_lane2 (
    .clk(clk), .rst(rst), .load(start_acc), .adv(xfer), .q(lane2));
  lfsr8_lane #(.SEED(LANE3_SEED), .STEPS(STEPS)) u_lane3 (
    .clk(clk), .rst(rst), .load(start_acc), .adv(xfer), .q(lane3));

  assign a        = {lane2, lane0};
  assign b        = {lane3, lane1};
  assign in_valid = (state_q == RUN);
  assign busy     = (state_q == RUN) || (state_q == DRAIN);
  assign done     = (state_q == DONE);
  assign err      = err_q;

`ifdef STIM_SEQ_SIGNATURE_EN
  logic [31:0] sig_q, sig_d;
  logic [31:0] res_ext;

  always_comb begin
    res_ext              = '0;
    res_ext[RES_W-1:0]   = res_data;
    sig_d                = sig_q;
    if (start_acc) begin
      sig_d = MISR_INIT;
    end else if (res_ok) begin
      sig_d = misr_step(sig_q, res_ext);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= MISR_INIT;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign sig = sig_q;
`else
  logic res_data_unused;
  assign res_data_unused = ^res_data;
  assign sig             = 32'h0;
`endif

endmodule

// File: tb/tb_stim_sequencer.sv
// Directed and randomised campaigns against a lane/MISR reference model.
module tb_stim_sequencer;

  localparam int CNT_W = 16;
  localparam int RES_W = 32;
`ifdef STIM_SEQ_SIGNATURE_EN
  localparam bit SIG_ON = 1'b1;
`else
  localparam bit SIG_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_vec;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      a;
  logic [15:0]      b;
  logic             res_valid;
  logic [RES_W-1:0] res_data;
  logic             busy;
  logic             done;
  logic             err;
  logic [31:0]      sig;

  int          total = 0;
  int          bad = 0;
  logic [31:0] exp_sig;
  logic [7:0]  lane[4];

  stim_sequencer #(.STEPS(3), .CNT_W(CNT_W), .RES_W(RES_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_vec(num_vec),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .res_valid(res_valid), .res_data(res_data),
    .busy(busy), .done(done), .err(err), .sig(sig));

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Three applications of the lane rule per accepted vector.
  function automatic logic [7:0] lane_adv(input logic [7:0] r);
    logic [7:0] x;
    x = r;
    for (int s = 0; s < 3; s++) x = {x[6:0], x[3] ^ x[4] ^ x[5] ^ x[7]};
    return x;
  endfunction

  function automatic logic [31:0] misr(input logic [31:0] s, input logic [31:0] d);
    return {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]} ^ d;
  endfunction

  task automatic seed_model();
    lane[0] = 8'h55; lane[1] = 8'h5A; lane[2] = 8'h6A; lane[3] = 8'hAB;
  endtask

  task automatic campaign(input int n, input int rdy_pct);
    int sent = 0;
    int got = 0;
    int k = 0;
    seed_model();
    exp_sig = 32'hFFFF_FFFF;
    num_vec = CNT_W'(n);
    start = 1'b1;
    cyc();
    start = 1'b0;
    while (!done && k < 400) begin
      chk("busy_in_run", busy, 1);
      chk("no_extra_valid", in_valid && (sent >= n), 0);
      if (in_valid) begin
        chk("a_stream", a, {lane[2], lane[0]});
        chk("b_stream", b, {lane[3], lane[1]});
      end
      in_ready  = (rdy_pct < 0) ? (k % 2 == 0) : ($urandom_range(99) < rdy_pct);
      res_valid = (got < sent) && ($urandom_range(1) == 1);
      res_data  = $urandom;
      if (res_valid) begin
        got++;
        exp_sig = misr(exp_sig, res_data);
      end
      if (in_valid && in_ready) begin
        sent++;
        for (int i = 0; i < 4; i++) lane[i] = lane_adv(lane[i]);
      end
      cyc();
      k++;
    end
    in_ready  = 1'b0;
    res_valid = 1'b0;
    chk("run_done", done, 1);
    chk("run_transfers", sent, n);
    chk("run_results", got, n);
    chk("run_err", err, 0);
    chk("run_sig", sig, SIG_ON ? exp_sig : 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; num_vec = '0;
    in_ready = 1'b0; res_valid = 1'b0; res_data = '0;
    cyc(); cyc();
    rst = 1'b0;

    chk("rst_a", a, 32'h6A55);
    chk("rst_b", b, 32'hAB5A);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_sig", sig, SIG_ON ? 32'hFFFF_FFFF : 32'h0);

    res_valid = 1'b1; res_data = 32'h1234_5678;
    cyc();
    res_valid = 1'b0;
    chk("err_idle_result", err, 1);
    chk("sig_idle_result", sig, SIG_ON ? 32'hFFFF_FFFF : 32'h0);

    for (int rep = 0; rep < 2; rep++) begin
      num_vec = 16'd1; start = 1'b1;
      cyc();
      start = 1'b0;
      chk("one_err_cleared", err, 0);
      chk("one_valid", in_valid, 1);
      chk("one_a0", a, 32'h6A55);
      chk("one_b0", b, 32'hAB5A);
      in_ready = 1'b1;
      cyc();
      in_ready = 1'b0;
      chk("one_valid_drop", in_valid, 0);
      chk("one_a1_lo", a[7:0], 32'hAF);
      chk("one_b1_lo", b[7:0], 32'hD2);
      chk("one_drain_busy", busy, 1);
      chk("one_drain_done", done, 0);
      res_valid = 1'b1; res_data = '0;
      cyc();
      res_valid = 1'b0;
      chk("one_done", done, 1);
      chk("one_busy_off", busy, 0);
      chk("one_sig", sig, SIG_ON ? 32'hFFFF_FFFE : 32'h0);
    end

    num_vec = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("zero_valid_c1", in_valid, 0);
    cyc();
    chk("zero_done", done, 1);
    chk("zero_valid_c2", in_valid, 0);
    chk("zero_busy", busy, 0);

    campaign(4, -1);

    res_valid = 1'b1; res_data = $urandom;
    cyc();
    res_valid = 1'b0;
    chk("err_extra_result", err, 1);
    chk("done_after_extra", done, 1);
    chk("sig_after_extra", sig, SIG_ON ? exp_sig : 32'h0);
    num_vec = 16'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    chk("err_cleared_by_start", err, 0);

    num_vec = 16'd5; start = 1'b1;
    cyc();
    start = 1'b0; in_ready = 1'b1;
    cyc(); cyc();
    seed_model();
    for (int t = 0; t < 2; t++)
      for (int i = 0; i < 4; i++) lane[i] = lane_adv(lane[i]);
    chk("mid_a", a, {lane[2], lane[0]});
    chk("mid_b", b, {lane[3], lane[1]});
    chk("mid_busy", busy, 1);
    rst = 1'b1; in_ready = 1'b0;
    cyc();
    rst = 1'b0;
    chk("mrst_a", a, 32'h6A55);
    chk("mrst_b", b, 32'hAB5A);
    chk("mrst_in_valid", in_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_err", err, 0);
    chk("mrst_sig", sig, SIG_ON ? 32'hFFFF_FFFF : 32'h0);
    campaign(3, 70);

    for (int r = 0; r < 6; r++) begin
      campaign(int'($urandom_range(8, 1)), int'($urandom_range(100, 30)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
